// File: rtl/mem_req_pkg.sv
// Shared memory-request types: command encodings and the {cmd, addr, dta} entry
// passed from the video clients through mem_req_fifo to mem_shim.
package mem_req_pkg;

    localparam int unsigned MEM_CMD_W  = 2;
    localparam int unsigned MEM_ADDR_W = 22;
    localparam int unsigned MEM_DATA_W = 64;

    localparam logic [MEM_CMD_W-1:0] CMD_NOOP    = 2'd0;
    localparam logic [MEM_CMD_W-1:0] CMD_REFRESH = 2'd1;
    localparam logic [MEM_CMD_W-1:0] CMD_READ    = 2'd2;
    localparam logic [MEM_CMD_W-1:0] CMD_WRITE   = 2'd3;

    typedef struct packed {
        logic [MEM_CMD_W-1:0]  cmd;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] dta;
    } mem_req_t;

    localparam int unsigned MEM_REQ_W = $bits(mem_req_t);

endpackage

// File: rtl/mem_req_fifo_if.sv
// Push side (video clients) and pop side (mem_shim) of the memory request queue.
interface mem_req_fifo_if;
    import mem_req_pkg::*;

    logic [MEM_CMD_W-1:0]  mem_req_wr_cmd;
    logic [MEM_ADDR_W-1:0] mem_req_wr_addr;
    logic [MEM_DATA_W-1:0] mem_req_wr_dta;
    logic                  mem_req_wr_en;
    logic                  mem_req_wr_almost_full;
    logic                  mem_req_wr_full;

    logic                  mem_req_rd_en;
    logic [MEM_CMD_W-1:0]  mem_req_rd_cmd;
    logic [MEM_ADDR_W-1:0] mem_req_rd_addr;
    logic [MEM_DATA_W-1:0] mem_req_rd_dta;
    logic                  mem_req_rd_valid;

    // Requesting side: drives pushes and pops, observes flags and popped data.
    modport master (
        output mem_req_wr_cmd, mem_req_wr_addr, mem_req_wr_dta, mem_req_wr_en,
        input  mem_req_wr_almost_full, mem_req_wr_full,
        output mem_req_rd_en,
        input  mem_req_rd_cmd, mem_req_rd_addr, mem_req_rd_dta, mem_req_rd_valid
    );

    modport slave (
        input  mem_req_wr_cmd, mem_req_wr_addr, mem_req_wr_dta, mem_req_wr_en,
        output mem_req_wr_almost_full, mem_req_wr_full,
        input  mem_req_rd_en,
        output mem_req_rd_cmd, mem_req_rd_addr, mem_req_rd_dta, mem_req_rd_valid
    );

endinterface

// File: rtl/mem_req_fifo_ram.sv
// Simple dual-port entry store: synchronous write, registered read address, so
// it fits a block RAM with an unregistered data output.
module mem_req_fifo_ram
    import mem_req_pkg::*;
#(
    parameter int unsigned AddrW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  mem_req_t         wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output mem_req_t         rdata_o
);

    localparam int unsigned Depth = 1 << AddrW;

    mem_req_t         mem_q [Depth];
    logic [AddrW-1:0] raddr_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Address register is reset so it tracks the read pointer from the first cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raddr_q <= '0;
        end else begin
            raddr_q <= raddr_i;
        end
    end

    assign rdata_o = mem_q[raddr_q];

endmodule

// File: rtl/mem_req_fifo.sv
// Memory request queue in front of mem_shim: pop-driven read port with a single
// output register, almost-full backpressure and a sticky overflow flag.
module mem_req_fifo
    import mem_req_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned AF_MARGIN  = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_req_fifo_if.slave       req,
    output logic [DEPTH_LOG2:0] fill_level,
    output logic                overflow
);

    localparam int unsigned CntW  = DEPTH_LOG2 + 1;
    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam logic [CntW-1:0] CountFull = CntW'(Depth);
    localparam logic [CntW-1:0] AfThresh  = CntW'(Depth - AF_MARGIN);

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  rd_valid_q, rd_valid_d;
    mem_req_t              rd_entry_q, rd_entry_d;

    logic     full;
    logic     push;
    logic     pop;
    mem_req_t wr_entry;
    mem_req_t ram_rdata;

    assign full = (count_q == CountFull);

    assign wr_entry.cmd  = req.mem_req_wr_cmd;
    assign wr_entry.addr = req.mem_req_wr_addr;
    assign wr_entry.dta  = req.mem_req_wr_dta;

    always_comb begin
        push       = req.mem_req_wr_en && !full;
        pop        = req.mem_req_rd_en && (count_q != '0);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        rd_valid_d = pop;
        rd_entry_d = rd_entry_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            rd_entry_d = ram_rdata;
        end
        // A pop in the same cycle never frees room for a push refused on full.
        if (req.mem_req_wr_en && full) begin
            overflow_d = 1'b1;
        end
        count_d = count_q + CntW'(push) - CntW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_entry_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            rd_valid_q <= rd_valid_d;
            rd_entry_q <= rd_entry_d;
        end
    end

    // Read address looks one pointer ahead so the RAM already shows mem[rd_ptr_q].
    mem_req_fifo_ram #(
        .AddrW (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_d),
        .rdata_o (ram_rdata)
    );

    assign req.mem_req_wr_full        = full;
    assign req.mem_req_wr_almost_full = (count_q >= AfThresh);
    assign req.mem_req_rd_valid       = rd_valid_q;
    assign req.mem_req_rd_cmd         = rd_entry_q.cmd;
    assign req.mem_req_rd_addr        = rd_entry_q.addr;
    assign req.mem_req_rd_dta         = rd_entry_q.dta;
    assign fill_level                 = count_q;
    assign overflow                   = overflow_q;

endmodule

// File: tb/tb_mem_req_fifo.sv
// Directed self-checking bench for mem_req_fifo (16 entries, almost-full margin 4).
module tb_mem_req_fifo;
    import mem_req_pkg::*;

    logic       clk;
    logic       rst;
    logic [4:0] fill_level;
    logic       overflow;
    int         checks;
    int         errors;

    mem_req_fifo_if req_if ();

    mem_req_fifo #(
        .DEPTH_LOG2 (4),
        .AF_MARGIN  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req_if),
        .fill_level (fill_level),
        .overflow   (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic mem_req_t entry(input int i);
        mem_req_t e;
        e.cmd  = 2'(i);
        e.addr = 22'h2A0000 + 22'(i);
        e.dta  = {32'hC0DE0000 + 32'(i), 32'h12340000 + 32'(i * 7)};
        return e;
    endfunction

    function automatic mem_req_t rd_word();
        mem_req_t e;
        e.cmd  = req_if.mem_req_rd_cmd;
        e.addr = req_if.mem_req_rd_addr;
        e.dta  = req_if.mem_req_rd_dta;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wr(input mem_req_t e, input logic en);
        req_if.mem_req_wr_cmd  = e.cmd;
        req_if.mem_req_wr_addr = e.addr;
        req_if.mem_req_wr_dta  = e.dta;
        req_if.mem_req_wr_en   = en;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_wr('0, 1'b0);
        req_if.mem_req_rd_en = 1'b0;
        #2;
        checks++;
        if ({req_if.mem_req_rd_valid, fill_level, overflow, req_if.mem_req_wr_full,
             req_if.mem_req_wr_almost_full} !== 9'd0 || rd_word() !== '0) begin
            errors++;
            $display("FAIL reset_state: valid=%b fill=%0d ovf=%b full=%b af=%b rd=%h, need all 0",
                     req_if.mem_req_rd_valid, fill_level, overflow, req_if.mem_req_wr_full,
                     req_if.mem_req_wr_almost_full, rd_word());
        end
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_basic();
        mem_req_t a;
        mem_req_t b;
        a.cmd = CMD_WRITE; a.addr = 22'h123456; a.dta = 64'hDEADBEEFCAFEBABE;
        b.cmd = CMD_READ;  b.addr = 22'h1BCDEF; b.dta = 64'h0;
        req_if.mem_req_rd_en = 1'b1;
        drive_wr(a, 1'b1);
        tick();
        checks++;
        if (req_if.mem_req_rd_valid !== 1'b0 || fill_level !== 5'd1) begin
            errors++;
            $display("FAIL basic_first: valid=%b fill=%0d, need valid=0 fill=1",
                     req_if.mem_req_rd_valid, fill_level);
        end
        drive_wr(b, 1'b1);
        tick();
        checks++;
        if (req_if.mem_req_rd_valid !== 1'b1 || rd_word() !== a || fill_level !== 5'd1) begin
            errors++;
            $display("FAIL basic_pop_a: valid=%b rd=%h fill=%0d, need valid=1 rd=%h fill=1",
                     req_if.mem_req_rd_valid, rd_word(), fill_level, a);
        end
        drive_wr(b, 1'b0);
        tick();
        checks++;
        if (req_if.mem_req_rd_valid !== 1'b1 || rd_word() !== b || fill_level !== 5'd0) begin
            errors++;
            $display("FAIL basic_pop_b: valid=%b rd=%h fill=%0d, need valid=1 rd=%h fill=0",
                     req_if.mem_req_rd_valid, rd_word(), fill_level, b);
        end
        tick();
        checks++;
        if (req_if.mem_req_rd_valid !== 1'b0 || rd_word() !== b || fill_level !== 5'd0) begin
            errors++;
            $display("FAIL basic_idle_hold: valid=%b rd=%h fill=%0d, need valid=0 rd=%h fill=0",
                     req_if.mem_req_rd_valid, rd_word(), fill_level, b);
        end
    endtask

    task automatic test_empty_latency();
        mem_req_t c;
        c = entry(77);
        req_if.mem_req_rd_en = 1'b1;
        drive_wr(c, 1'b1);
        tick();
        checks++;
        if (req_if.mem_req_rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_n1: valid=%b, need 0", req_if.mem_req_rd_valid);
        end
        drive_wr(c, 1'b0);
        tick();
        checks++;
        if (req_if.mem_req_rd_valid !== 1'b1 || rd_word() !== c) begin
            errors++;
            $display("FAIL latency_n2: valid=%b rd=%h, need valid=1 rd=%h",
                     req_if.mem_req_rd_valid, rd_word(), c);
        end
        tick();
        checks++;
        if (req_if.mem_req_rd_valid !== 1'b0 || fill_level !== 5'd0) begin
            errors++;
            $display("FAIL latency_after: valid=%b fill=%0d, need valid=0 fill=0",
                     req_if.mem_req_rd_valid, fill_level);
        end
    endtask

    task automatic test_fill_overflow();
        req_if.mem_req_rd_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive_wr(entry(i), 1'b1);
            tick();
            if (i == 10) begin
                checks++;
                if (req_if.mem_req_wr_almost_full !== 1'b0 || fill_level !== 5'd11) begin
                    errors++;
                    $display("FAIL af_at_11: af=%b fill=%0d, need af=0 fill=11",
                             req_if.mem_req_wr_almost_full, fill_level);
                end
            end
            if (i == 11) begin
                checks++;
                if (req_if.mem_req_wr_almost_full !== 1'b1 || req_if.mem_req_wr_full !== 1'b0 ||
                    fill_level !== 5'd12) begin
                    errors++;
                    $display("FAIL af_at_12: af=%b full=%b fill=%0d, need af=1 full=0 fill=12",
                             req_if.mem_req_wr_almost_full, req_if.mem_req_wr_full, fill_level);
                end
            end
            if (i == 14) begin
                checks++;
                if (req_if.mem_req_wr_full !== 1'b0 || fill_level !== 5'd15) begin
                    errors++;
                    $display("FAIL full_at_15: full=%b fill=%0d, need full=0 fill=15",
                             req_if.mem_req_wr_full, fill_level);
                end
            end
        end
        checks++;
        if (req_if.mem_req_wr_full !== 1'b1 || fill_level !== 5'd16 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_at_16: full=%b fill=%0d ovf=%b, need full=1 fill=16 ovf=0",
                     req_if.mem_req_wr_full, fill_level, overflow);
        end
        drive_wr(entry(99), 1'b1);
        tick();
        checks++;
        if (overflow !== 1'b1 || fill_level !== 5'd16) begin
            errors++;
            $display("FAIL overflow_push: ovf=%b fill=%0d, need ovf=1 fill=16",
                     overflow, fill_level);
        end
        drive_wr(entry(99), 1'b0);
        req_if.mem_req_rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++;
            if (req_if.mem_req_rd_valid !== 1'b1 || rd_word() !== entry(i)) begin
                errors++;
                $display("FAIL drain_%0d: valid=%b rd=%h, need valid=1 rd=%h",
                         i, req_if.mem_req_rd_valid, rd_word(), entry(i));
            end
        end
        tick();
        checks++;
        if (req_if.mem_req_rd_valid !== 1'b0 || fill_level !== 5'd0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL drain_end: valid=%b fill=%0d ovf=%b, need valid=0 fill=0 ovf=1",
                     req_if.mem_req_rd_valid, fill_level, overflow);
        end
    endtask

    task automatic test_back_to_back();
        req_if.mem_req_rd_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_wr(entry(100 + i), 1'b1);
            tick();
        end
        req_if.mem_req_rd_en = 1'b1;
        for (int c = 0; c < 40; c++) begin
            drive_wr(entry(105 + c), 1'b1);
            tick();
            checks++;
            if (fill_level !== 5'd5 || req_if.mem_req_rd_valid !== 1'b1 ||
                rd_word() !== entry(100 + c)) begin
                errors++;
                $display("FAIL steady_%0d: fill=%0d valid=%b rd=%h, need fill=5 valid=1 rd=%h",
                         c, fill_level, req_if.mem_req_rd_valid, rd_word(), entry(100 + c));
            end
        end
        drive_wr(entry(0), 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (req_if.mem_req_rd_valid !== 1'b1 || rd_word() !== entry(140 + i)) begin
                errors++;
                $display("FAIL steady_drain_%0d: valid=%b rd=%h, need valid=1 rd=%h",
                         i, req_if.mem_req_rd_valid, rd_word(), entry(140 + i));
            end
        end
        tick();
        checks++;
        if (req_if.mem_req_rd_valid !== 1'b0 || fill_level !== 5'd0) begin
            errors++;
            $display("FAIL steady_end: valid=%b fill=%0d, need valid=0 fill=0",
                     req_if.mem_req_rd_valid, fill_level);
        end
    endtask

    task automatic test_reset_mid();
        req_if.mem_req_rd_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_wr(entry(200 + i), 1'b1);
            tick();
        end
        drive_wr(entry(0), 1'b0);
        req_if.mem_req_rd_en = 1'b1;
        tick();
        checks++;
        if (req_if.mem_req_rd_valid !== 1'b1 || rd_word() !== entry(200)) begin
            errors++;
            $display("FAIL pre_reset_pop: valid=%b rd=%h, need valid=1 rd=%h",
                     req_if.mem_req_rd_valid, rd_word(), entry(200));
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (req_if.mem_req_rd_valid !== 1'b0 || fill_level !== 5'd0 || overflow !== 1'b0 ||
            rd_word() !== '0) begin
            errors++;
            $display("FAIL async_reset: valid=%b fill=%0d ovf=%b rd=%h, need all 0",
                     req_if.mem_req_rd_valid, fill_level, overflow, rd_word());
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (req_if.mem_req_rd_valid !== 1'b0 || fill_level !== 5'd0) begin
                errors++;
                $display("FAIL post_reset_%0d: valid=%b fill=%0d, need valid=0 fill=0",
                         i, req_if.mem_req_rd_valid, fill_level);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_empty_latency();
        test_fill_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_req_fifo.md
Name: mem_req_fifo

Overview:
Request queue directly upstream of mem_shim. It buffers memory commands (cmd/addr/data) from the motion-compensation and frame-store clients. It presents them on the pop-driven mem_req_rd_* interface that mem_shim consumes: pop with mem_req_rd_en, data and valid arrive one cycle later. It provides almost-full backpressure to the writers and a sticky overflow flag for debug.

Parameters:
DEPTH_LOG2, 4, log2 of entry count (16 entries).
AF_MARGIN, 4, mem_req_wr_almost_full asserts when free slots <= AF_MARGIN.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-high
mem_req_wr_cmd  in  2  command (NOOP=0, REFRESH=1, READ=2, WRITE=3)
mem_req_wr_addr  in  22  64-bit-word address
mem_req_wr_dta  in  64  write data (don't-care for READ)
mem_req_wr_en  in  1  push request
mem_req_wr_almost_full  out  1  count >= 2^DEPTH_LOG2 - AF_MARGIN
mem_req_wr_full  out  1  count == 2^DEPTH_LOG2
mem_req_rd_en  in  1  pop request from mem_shim
mem_req_rd_cmd  out  2  popped command
mem_req_rd_addr  out  22  popped address
mem_req_rd_dta  out  64  popped data
mem_req_rd_valid  out  1  rd_* hold a freshly popped entry this cycle
fill_level  out  DEPTH_LOG2+1  current entry count
overflow  out  1  sticky: push attempted while full

Behaviour:
- Reset: the asynchronous reset is active-high, on one clock. It applies immediately and clears rd_ptr, wr_ptr, count, mem_req_rd_valid, overflow, and rd_cmd/addr/dta (all 0). Contents are discarded, including a reset mid-operation; no entry is emitted after reset release.
- Storage: 2^DEPTH_LOG2 entries of 88 bits {cmd, addr, dta}. Pointers are DEPTH_LOG2 bits and wrap naturally. Count is a separate register of DEPTH_LOG2+1 bits.
- Push accepted iff wr_en && count < 2^DEPTH_LOG2, using the registered count.
- A push while full is dropped, sets overflow (held until rst) and leaves the pointers unchanged. A pop in the same cycle does not rescue it.
- Pop occurs iff rd_en && count != 0, using the registered count.
  - On pop, the entry at rd_ptr is registered into rd_cmd/addr/dta at that edge, and rd_valid=1 in the following cycle.
  - rd_valid is high for exactly one cycle per pop.
  - Back-to-back pops give rd_valid high on consecutive cycles with successive entries.
- rd_en while empty: no pop, rd_valid=0 next cycle, no error. mem_shim holds rd_en high while idle, so this case is normal.
- When rd_valid=0, rd_cmd/addr/dta hold the last popped values.
- Latency: push at edge N → entry readable → earliest pop at edge N+1 → rd_valid during cycle after N+1. Minimum write-to-valid latency is 2 cycles.
- Simultaneous push and pop on an empty FIFO: pop is refused (count=0); the push lands.
- Simultaneous push and pop with 0 < count < full: count unchanged, both proceed.
- Count update each edge: count + push_accepted - pop.
- almost_full and full are combinational from the registered count; there are no other combinational paths from inputs to outputs.
- Commands are passed through uninterpreted; the FIFO preserves order.
- The overflow and almost_full semantics leave writers at least AF_MARGIN cycles of slack.
- No state machine beyond the pointer/count logic. The output register is the single pipeline stage.

Decomposition:
- Package mem_req_pkg:
  - CMD_NOOP/CMD_REFRESH/CMD_READ/CMD_WRITE localparams (2-bit)
  - MEM_ADDR_W=22, MEM_DATA_W=64
  - mem_req_t packed struct {cmd, addr, dta}
- mem_shim imports the same package.
- Sub-module mem_req_fifo_ram: simple dual-port array with a synchronous-write, registered-read port. It maps to M10K. Pointers, count, flags and the output register stay in mem_req_fifo.

Test Plan:
- Push WRITE 0x123456/0xDEADBEEFCAFEBABE, then READ 0x1BCDEF; hold rd_en=1 → rd_valid=1 on two consecutive cycles with those entries in order; then rd_valid=0, fill_level=0.
- Push 12 entries with rd_en=0 → almost_full=1 at fill 12, full=0. Push 4 more → full=1, fill=16. Push a 17th → overflow=1, fill stays 16. Drain → the first 16 values arrive in order.
- Empty FIFO, rd_en=1 with a push at edge N → no valid at N+1, rd_valid=1 in the cycle after N+1 with the pushed data.
- Fill level 5, push and pop every cycle for 40 cycles → fill_level constant 5, pointers wrap, output order matches the input sequence.
- Fill 3 entries, assert rst for one cycle mid-pop → rd_valid=0, fill_level=0, overflow=0 immediately. No stale entry appears after release with rd_en=1.
